// File: rtl/operand_forward_stage.sv
// ID->EX operand stage: picks each source operand from RF / MEM / WB forwarding paths,
// inserts one bubble on load-use, and holds EX while a multi-cycle M-extension op is busy.
module operand_forward_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  ENABLE_RS1_MEM_STAGE,
    input  logic                  ENABLE_RS2_MEM_STAGE,
    input  logic                  ENABLE_RS1_WB_STAGE,
    input  logic                  ENABLE_RS2_WB_STAGE,
    input  logic [ADDR_WIDTH-1:0] RS1_ID,
    input  logic [ADDR_WIDTH-1:0] RS2_ID,
    input  logic [DATA_WIDTH-1:0] RS1_DATA_ID,
    input  logic [DATA_WIDTH-1:0] RS2_DATA_ID,
    input  logic                  ID_VALID,
    input  logic [DATA_WIDTH-1:0] MEM_FWD_DATA,
    input  logic [DATA_WIDTH-1:0] WB_FWD_DATA,
    input  logic                  MEM_WRITE_EN,
    input  logic                  WB_WRITE_EN,
    input  logic                  ALU_IS_LOAD,
    input  logic                  EX_BUSY,
    input  logic                  FLUSH,
    output logic [DATA_WIDTH-1:0] OP1_EX,
    output logic [DATA_WIDTH-1:0] OP2_EX,
    output logic [1:0]            FWD_SRC1,
    output logic [1:0]            FWD_SRC2,
    output logic                  EX_VALID,
    output logic                  STALL_REQ,
    output logic [CNT_WIDTH-1:0]  STALL_COUNT,
    output logic                  STATE_DBG
);

    // Handshake: STALL_REQ is a same-cycle hold request to the front end; when high,
    // the ID instruction is not consumed at the coming edge and must be presented again.

    typedef enum logic {
        RUN     = 1'b0,
        LU_WAIT = 1'b1
    } state_t;

    localparam logic [1:0] SRC_RF  = 2'b00;
    localparam logic [1:0] SRC_MEM = 2'b01;
    localparam logic [1:0] SRC_WB  = 2'b10;

    state_t                state_q;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] op1_sel;
    logic [DATA_WIDTH-1:0] op2_sel;
    logic [1:0]            src1_sel;
    logic [1:0]            src2_sel;
    logic                  load_use;
    logic                  bubble;

    // x0 is hardwired zero, so it is never forwarded; the newer MEM result beats WB.
    always_comb begin
        op1_sel  = RS1_DATA_ID;
        src1_sel = SRC_RF;
        if (RS1_ID != '0) begin
            if (ENABLE_RS1_MEM_STAGE && MEM_WRITE_EN) begin
                op1_sel  = MEM_FWD_DATA;
                src1_sel = SRC_MEM;
            end else if (ENABLE_RS1_WB_STAGE && WB_WRITE_EN) begin
                op1_sel  = WB_FWD_DATA;
                src1_sel = SRC_WB;
            end
        end
    end

    always_comb begin
        op2_sel  = RS2_DATA_ID;
        src2_sel = SRC_RF;
        if (RS2_ID != '0) begin
            if (ENABLE_RS2_MEM_STAGE && MEM_WRITE_EN) begin
                op2_sel  = MEM_FWD_DATA;
                src2_sel = SRC_MEM;
            end else if (ENABLE_RS2_WB_STAGE && WB_WRITE_EN) begin
                op2_sel  = WB_FWD_DATA;
                src2_sel = SRC_WB;
            end
        end
    end

    always_comb begin
        load_use   = ID_VALID && ALU_IS_LOAD &&
                     ((ENABLE_RS1_MEM_STAGE && (RS1_ID != '0)) ||
                      (ENABLE_RS2_MEM_STAGE && (RS2_ID != '0)));
        bubble     = (state_q == RUN) && load_use;
        STALL_REQ  = !RESET && !FLUSH && (EX_BUSY || bubble);
        state_next = state_q;
        if (FLUSH) begin
            state_next = RUN;
        end else if (EX_BUSY) begin
            state_next = state_q;
        end else if (bubble) begin
            state_next = LU_WAIT;
        end else begin
            state_next = RUN;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= RUN;
        end else begin
            state_q <= state_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET || FLUSH) begin
            OP1_EX   <= '0;
            OP2_EX   <= '0;
            FWD_SRC1 <= SRC_RF;
            FWD_SRC2 <= SRC_RF;
            EX_VALID <= 1'b0;
        end else if (EX_BUSY) begin
            OP1_EX   <= OP1_EX;
            OP2_EX   <= OP2_EX;
            FWD_SRC1 <= FWD_SRC1;
            FWD_SRC2 <= FWD_SRC2;
            EX_VALID <= EX_VALID;
        end else if (bubble) begin
            OP1_EX   <= '0;
            OP2_EX   <= '0;
            FWD_SRC1 <= SRC_RF;
            FWD_SRC2 <= SRC_RF;
            EX_VALID <= 1'b0;
        end else begin
            OP1_EX   <= op1_sel;
            OP2_EX   <= op2_sel;
            FWD_SRC1 <= src1_sel;
            FWD_SRC2 <= src2_sel;
            EX_VALID <= ID_VALID;
        end
    end

    // Saturating so long-running profiles never see the counter wrap back to small values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            STALL_COUNT <= '0;
        end else if (STALL_REQ && (STALL_COUNT != '1)) begin
            STALL_COUNT <= STALL_COUNT + 1'b1;
        end
    end

    assign STATE_DBG = (state_q == LU_WAIT);

endmodule

// File: tb/tb_operand_forward_stage.sv
// Randomized bench for operand_forward_stage: a behavioural model tracks every output each
// cycle, and directed scenarios pin the model with hand-computed literals.
module tb_operand_forward_stage;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        ENABLE_RS1_MEM_STAGE, ENABLE_RS2_MEM_STAGE;
    logic        ENABLE_RS1_WB_STAGE, ENABLE_RS2_WB_STAGE;
    logic [4:0]  RS1_ID, RS2_ID;
    logic [31:0] RS1_DATA_ID, RS2_DATA_ID;
    logic        ID_VALID;
    logic [31:0] MEM_FWD_DATA, WB_FWD_DATA;
    logic        MEM_WRITE_EN, WB_WRITE_EN, ALU_IS_LOAD, EX_BUSY, FLUSH;
    logic [31:0] OP1_EX, OP2_EX;
    logic [1:0]  FWD_SRC1, FWD_SRC2;
    logic        EX_VALID, STALL_REQ, STATE_DBG;
    logic [15:0] STALL_COUNT;

    int compared   = 0;
    int mismatched = 0;

    operand_forward_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(16)) dut (
        .CLK(CLK), .RESET(RESET),
        .ENABLE_RS1_MEM_STAGE(ENABLE_RS1_MEM_STAGE), .ENABLE_RS2_MEM_STAGE(ENABLE_RS2_MEM_STAGE),
        .ENABLE_RS1_WB_STAGE(ENABLE_RS1_WB_STAGE), .ENABLE_RS2_WB_STAGE(ENABLE_RS2_WB_STAGE),
        .RS1_ID(RS1_ID), .RS2_ID(RS2_ID), .RS1_DATA_ID(RS1_DATA_ID), .RS2_DATA_ID(RS2_DATA_ID),
        .ID_VALID(ID_VALID), .MEM_FWD_DATA(MEM_FWD_DATA), .WB_FWD_DATA(WB_FWD_DATA),
        .MEM_WRITE_EN(MEM_WRITE_EN), .WB_WRITE_EN(WB_WRITE_EN), .ALU_IS_LOAD(ALU_IS_LOAD),
        .EX_BUSY(EX_BUSY), .FLUSH(FLUSH),
        .OP1_EX(OP1_EX), .OP2_EX(OP2_EX), .FWD_SRC1(FWD_SRC1), .FWD_SRC2(FWD_SRC2),
        .EX_VALID(EX_VALID), .STALL_REQ(STALL_REQ), .STALL_COUNT(STALL_COUNT),
        .STATE_DBG(STATE_DBG)
    );

    // Clock / reset
    always #5 CLK = ~CLK;

    // Behavioural model: what EX must hold after each edge, plus "bubble already given".
    logic [31:0] m_op1, m_op2;
    logic [1:0]  m_src1, m_src2;
    logic        m_valid, m_waiting, m_started;
    logic [15:0] m_cnt;
    initial m_started = 1'b0;

    function automatic logic [33:0] pick(input logic [4:0] rs, input logic en_mem,
                                         input logic en_wb, input logic [31:0] rf);
        if (rs == 5'd0) return {2'd0, rf};
        if (en_mem && MEM_WRITE_EN) return {2'd1, MEM_FWD_DATA};
        if (en_wb && WB_WRITE_EN) return {2'd2, WB_FWD_DATA};
        return {2'd0, rf};
    endfunction

    function automatic logic hazard();
        return ID_VALID && ALU_IS_LOAD &&
               ((ENABLE_RS1_MEM_STAGE && RS1_ID != 0) || (ENABLE_RS2_MEM_STAGE && RS2_ID != 0));
    endfunction

    function automatic logic model_stall();
        if (RESET || FLUSH) return 1'b0;
        return EX_BUSY || (hazard() && !m_waiting);
    endfunction

    always @(posedge CLK) begin
        logic [33:0] p1, p2;
        p1 = pick(RS1_ID, ENABLE_RS1_MEM_STAGE, ENABLE_RS1_WB_STAGE, RS1_DATA_ID);
        p2 = pick(RS2_ID, ENABLE_RS2_MEM_STAGE, ENABLE_RS2_WB_STAGE, RS2_DATA_ID);
        if (RESET) begin
            {m_op1, m_op2, m_src1, m_src2, m_valid, m_waiting, m_cnt} = '0;
        end else begin
            if (model_stall() && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (FLUSH) begin
                {m_op1, m_op2, m_src1, m_src2, m_valid, m_waiting} = '0;
            end else if (EX_BUSY) begin
                // EX and the bubble bookkeeping stay frozen
            end else if (hazard() && !m_waiting) begin
                {m_op1, m_op2, m_src1, m_src2, m_valid} = '0;
                m_waiting = 1'b1;
            end else begin
                {m_src1, m_op1} = p1;
                {m_src2, m_op2} = p2;
                m_valid   = ID_VALID;
                m_waiting = 1'b0;
            end
        end
        m_started = 1'b1;
    end

    // Scoreboard / compare
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (m_started) begin
            chk("op1", OP1_EX, m_op1);
            chk("op2", OP2_EX, m_op2);
            chk("src1", FWD_SRC1, m_src1);
            chk("src2", FWD_SRC2, m_src2);
            chk("ex_valid", EX_VALID, m_valid);
            chk("stall_req", STALL_REQ, model_stall());
            chk("stall_count", STALL_COUNT, m_cnt);
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        RESET = 0; FLUSH = 0; EX_BUSY = 0; ALU_IS_LOAD = 0; ID_VALID = 0;
        ENABLE_RS1_MEM_STAGE = 0; ENABLE_RS2_MEM_STAGE = 0;
        ENABLE_RS1_WB_STAGE = 0; ENABLE_RS2_WB_STAGE = 0;
        MEM_WRITE_EN = 0; WB_WRITE_EN = 0;
        RS1_ID = 0; RS2_ID = 0; RS1_DATA_ID = 0; RS2_DATA_ID = 0;
        MEM_FWD_DATA = 0; WB_FWD_DATA = 0;
    endtask

    task automatic rand_inputs();
        ENABLE_RS1_MEM_STAGE = 1'($urandom_range(0, 1));
        ENABLE_RS2_MEM_STAGE = 1'($urandom_range(0, 1));
        ENABLE_RS1_WB_STAGE  = 1'($urandom_range(0, 1));
        ENABLE_RS2_WB_STAGE  = 1'($urandom_range(0, 1));
        RS1_ID       = 5'($urandom_range(0, 3));
        RS2_ID       = 5'($urandom_range(0, 3));
        RS1_DATA_ID  = $urandom;
        RS2_DATA_ID  = $urandom;
        MEM_FWD_DATA = $urandom;
        WB_FWD_DATA  = $urandom;
        ID_VALID     = ($urandom_range(0, 3) != 0);
        MEM_WRITE_EN = ($urandom_range(0, 3) != 0);
        WB_WRITE_EN  = ($urandom_range(0, 3) != 0);
        ALU_IS_LOAD  = ($urandom_range(0, 2) == 0);
        EX_BUSY      = ($urandom_range(0, 5) == 0);
        FLUSH        = ($urandom_range(0, 15) == 0);
        RESET        = ($urandom_range(0, 99) == 0);
    endtask

    task automatic do_reset();
        idle_inputs();
        RESET = 1;
        tick();
        RESET = 0;
    endtask

    initial begin
        idle_inputs();
        RESET = 1;
        #1;

        // 1: reset held two cycles under random inputs
        rand_inputs(); RESET = 1; tick();
        rand_inputs(); RESET = 1; tick();
        chk("rst_op1", OP1_EX, 0);
        chk("rst_op2", OP2_EX, 0);
        chk("rst_src", {FWD_SRC1, FWD_SRC2}, 0);
        chk("rst_valid", EX_VALID, 0);
        chk("rst_stall", STALL_REQ, 0);
        chk("rst_count", STALL_COUNT, 0);
        chk("rst_state", STATE_DBG, 0);

        // 2+3: MEM beats WB on rs1; x0 on rs2 never forwarded
        idle_inputs();
        ID_VALID = 1; RS1_ID = 5; ENABLE_RS1_MEM_STAGE = 1; ENABLE_RS1_WB_STAGE = 1;
        MEM_WRITE_EN = 1; WB_WRITE_EN = 1;
        MEM_FWD_DATA = 32'hAAAA0001; WB_FWD_DATA = 32'hBBBB0002;
        RS1_DATA_ID = 32'h0000_1111;
        RS2_ID = 0; ENABLE_RS2_MEM_STAGE = 1; RS2_DATA_ID = 0;
        tick();
        chk("fwd_mem_op1", OP1_EX, 32'hAAAA0001);
        chk("fwd_mem_src1", FWD_SRC1, 2'b01);
        chk("x0_op2", OP2_EX, 0);
        chk("x0_src2", FWD_SRC2, 2'b00);
        chk("fwd_valid", EX_VALID, 1);

        // 4: load-use bubble then WB forward
        do_reset();
        ID_VALID = 1; ALU_IS_LOAD = 1; ENABLE_RS1_MEM_STAGE = 1; RS1_ID = 7;
        MEM_WRITE_EN = 1; MEM_FWD_DATA = 32'hDEAD0000;
        #1 chk("lu_stall", STALL_REQ, 1);
        tick();
        chk("lu_bubble", EX_VALID, 0);
        chk("lu_state", STATE_DBG, 1);
        ALU_IS_LOAD = 0; ENABLE_RS1_MEM_STAGE = 0; ENABLE_RS1_WB_STAGE = 1;
        WB_WRITE_EN = 1; WB_FWD_DATA = 32'h12345678;
        #1 chk("lu_release", STALL_REQ, 0);
        tick();
        chk("lu_op1", OP1_EX, 32'h12345678);
        chk("lu_src1", FWD_SRC1, 2'b10);
        chk("lu_valid", EX_VALID, 1);
        chk("lu_count", STALL_COUNT, 1);

        // 4b: hazard still visible in LU_WAIT must not give a second bubble
        do_reset();
        ID_VALID = 1; ALU_IS_LOAD = 1; ENABLE_RS2_MEM_STAGE = 1; RS2_ID = 3; MEM_WRITE_EN = 1;
        tick();
        #1 chk("lu_once", STALL_REQ, 0);
        tick();
        chk("lu_once_valid", EX_VALID, 1);

        // 5: flush during LU_WAIT abandons the stall
        do_reset();
        ID_VALID = 1; ALU_IS_LOAD = 1; ENABLE_RS1_MEM_STAGE = 1; RS1_ID = 9; MEM_WRITE_EN = 1;
        tick();
        FLUSH = 1;
        #1 chk("flush_stall", STALL_REQ, 0);
        tick();
        chk("flush_valid", EX_VALID, 0);
        chk("flush_state", STATE_DBG, 0);
        FLUSH = 0; ALU_IS_LOAD = 0;
        #1 chk("flush_nostall", STALL_REQ, 0);

        // 6: EX_BUSY holds EX, then counter saturates
        do_reset();
        ID_VALID = 1; RS1_ID = 1; RS2_ID = 2; RS1_DATA_ID = 32'h11; RS2_DATA_ID = 32'h22;
        tick();
        for (int i = 0; i < 4; i++) begin
            rand_inputs(); RESET = 0; FLUSH = 0; EX_BUSY = 1;
            tick();
        end
        chk("busy_op1", OP1_EX, 32'h11);
        chk("busy_op2", OP2_EX, 32'h22);
        chk("busy_valid", EX_VALID, 1);
        chk("busy_count", STALL_COUNT, 4);
        for (int i = 0; i < 65536; i++) tick();
        chk("sat_count", STALL_COUNT, 16'hFFFF);
        tick();
        chk("sat_hold", STALL_COUNT, 16'hFFFF);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            tick();
        end

        @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
